// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - exception cause codes, controller FSM state type and default vector
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_TR   = 5'h0d;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - combinational M-stage exception priority encoder
// Trap cause is present only when EXC_TRAP_EN is defined.
module exc_prio_enc
  import exc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_int_take,
  input  logic              i_is_reserved,
  input  logic              i_is_overflow,
`ifdef EXC_TRAP_EN
  input  logic              i_is_trap,
`endif
  input  logic              i_is_syscall,
  input  logic              i_is_break,
  input  logic              i_is_load_adel,
  input  logic              i_is_store_ades,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              o_has_exc,
  output logic [4:0]        o_code,
  output logic [ADDR_W-1:0] o_bad_addr,
  output logic              o_bad_we
);

  always_comb begin
    o_has_exc  = 1'b1;
    o_code     = EXC_INT;
    o_bad_addr = '0;
    o_bad_we   = 1'b0;
    if (i_int_take) begin
      o_code = EXC_INT;
    end else if (i_pc[1:0] != 2'b00) begin
      o_code     = EXC_ADEL;
      o_bad_addr = i_pc;
      o_bad_we   = 1'b1;
    end else if (i_is_reserved) begin
      o_code = EXC_RI;
    end else if (i_is_overflow) begin
      o_code = EXC_OV;
`ifdef EXC_TRAP_EN
    end else if (i_is_trap) begin
      o_code = EXC_TR;
`endif
    end else if (i_is_syscall) begin
      o_code = EXC_SYS;
    end else if (i_is_break) begin
      o_code = EXC_BP;
    end else if (i_is_load_adel) begin
      o_code     = EXC_ADEL;
      o_bad_addr = i_mem_addr;
      o_bad_we   = 1'b1;
    end else if (i_is_store_ades) begin
      o_code     = EXC_ADES;
      o_bad_addr = i_mem_addr;
      o_bad_we   = 1'b1;
    end else begin
      o_has_exc = 1'b0;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - registered M-stage exception/interrupt controller with CP0 commit and redirect
// Optional trap cause enabled by EXC_TRAP_EN.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int                NUM_INT    = 8,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEFAULT)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               validM,
  input  logic               stallM,
  input  logic [ADDR_W-1:0]  pcM,
  input  logic [ADDR_W-1:0]  memAddrM,
  input  logic               inDelaySlotM,
  input  logic               isSyscallM,
  input  logic               isBreakM,
  input  logic               isEretM,
  input  logic               isLoadAdelM,
  input  logic               isStoreAdesM,
  input  logic               isOverflowM,
  input  logic               isReservedM,
`ifdef EXC_TRAP_EN
  input  logic               isTrapM,
`endif
  input  logic [NUM_INT-1:0] intReq,
  input  logic               statusIE,
  input  logic               statusEXL,
  input  logic [NUM_INT-1:0] statusIM,
  input  logic [ADDR_W-1:0]  epcIn,
  input  logic               redirectReady,
  output logic               flushReq,
  output logic               cp0We,
  output logic               badVAddrWe,
  output logic [4:0]         excCode,
  output logic [ADDR_W-1:0]  epcOut,
  output logic               bdOut,
  output logic [ADDR_W-1:0]  badVAddr,
  output logic               eretTaken,
  output logic               redirectValid,
  output logic [ADDR_W-1:0]  redirectPc,
  output logic               busy
);

  exc_state_t         r_state;
  exc_state_t         w_state_nxt;
  logic [NUM_INT-1:0] r_int_pend;
  logic               r_is_eret;
  logic               r_bad_we;
  logic [4:0]         r_exc_code;
  logic [ADDR_W-1:0]  r_epc;
  logic               r_bd;
  logic [ADDR_W-1:0]  r_badvaddr;
  logic [ADDR_W-1:0]  r_redirect_pc;

  logic               w_capture;
  logic               w_int_take;
  logic               w_has_exc;
  logic [4:0]         w_code;
  logic [ADDR_W-1:0]  w_bad_addr;
  logic               w_bad_we;
  logic               w_is_eret;
  logic               w_start;
  logic [NUM_INT-1:0] w_int_clr;

  assign w_capture  = validM & ~stallM & (r_state == ST_IDLE);
  assign w_int_take = statusIE & ~statusEXL & (|(r_int_pend & statusIM));
  assign w_is_eret  = isEretM & ~w_has_exc;
  assign w_start    = w_capture & (w_has_exc | w_is_eret);
  // Only the masked-in pending bits are consumed by a taken interrupt.
  assign w_int_clr  = (w_capture & w_int_take) ? (r_int_pend & statusIM) : '0;

  exc_prio_enc #(.ADDR_W(ADDR_W)) u_prio (
    .i_int_take      (w_int_take),
    .i_is_reserved   (isReservedM),
    .i_is_overflow   (isOverflowM),
`ifdef EXC_TRAP_EN
    .i_is_trap       (isTrapM),
`endif
    .i_is_syscall    (isSyscallM),
    .i_is_break      (isBreakM),
    .i_is_load_adel  (isLoadAdelM),
    .i_is_store_ades (isStoreAdesM),
    .i_pc            (pcM),
    .i_mem_addr      (memAddrM),
    .o_has_exc       (w_has_exc),
    .o_code          (w_code),
    .o_bad_addr      (w_bad_addr),
    .o_bad_we        (w_bad_we)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_int_pend <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_int_pend <= (r_int_pend | intReq) & ~w_int_clr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_start) w_state_nxt = ST_COMMIT;
      ST_COMMIT:   w_state_nxt = ST_REDIRECT;
      ST_REDIRECT: if (redirectReady) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Commit data is latched at capture; eret leaves the CP0 image untouched.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_is_eret     <= 1'b0;
      r_bad_we      <= 1'b0;
      r_exc_code    <= '0;
      r_epc         <= '0;
      r_bd          <= 1'b0;
      r_badvaddr    <= '0;
      r_redirect_pc <= '0;
    end else if (w_start) begin
      r_is_eret <= w_is_eret;
      if (w_is_eret) begin
        r_redirect_pc <= epcIn;
      end else begin
        r_exc_code    <= w_code;
        r_epc         <= inDelaySlotM ? (pcM - ADDR_W'(4)) : pcM;
        r_bd          <= inDelaySlotM;
        r_bad_we      <= w_bad_we;
        r_redirect_pc <= EXC_VECTOR;
        if (w_bad_we) r_badvaddr <= w_bad_addr;
      end
    end
  end

  always_comb begin
    flushReq      = (r_state == ST_COMMIT);
    cp0We         = (r_state == ST_COMMIT) & ~r_is_eret;
    badVAddrWe    = (r_state == ST_COMMIT) & ~r_is_eret & r_bad_we;
    eretTaken     = (r_state == ST_COMMIT) & r_is_eret;
    redirectValid = (r_state == ST_REDIRECT);
    busy          = (r_state != ST_IDLE);
    excCode       = r_exc_code;
    epcOut        = r_epc;
    bdOut         = r_bd;
    badVAddr      = r_badvaddr;
    redirectPc    = r_redirect_pc;
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - randomized bench for exception_ctrl against a cycle-level behavioural model
// Trap stimulus is applied only when EXC_TRAP_EN is defined.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        resetn, validM, stallM, inDelaySlotM;
  logic [31:0] pcM, memAddrM, epcIn;
  logic        isSyscallM, isBreakM, isEretM, isLoadAdelM, isStoreAdesM, isOverflowM, isReservedM;
`ifdef EXC_TRAP_EN
  logic        isTrapM;
`endif
  logic [7:0]  intReq, statusIM;
  logic        statusIE, statusEXL, redirectReady;
  logic        flushReq, cp0We, badVAddrWe, bdOut, eretTaken, redirectValid, busy;
  logic [4:0]  excCode;
  logic [31:0] epcOut, badVAddr, redirectPc;

  int n_vec = 0;
  int n_err = 0;

  // model: phase 0 = free, 1 = commit cycle, 2 = waiting for fetch to accept
  int          m_phase;
  logic [7:0]  m_pend;
  bit          m_eret, m_bd, m_badwe;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bad, m_rpc;

  always #5 clk = ~clk;

  exception_ctrl dut (
    .clk(clk), .resetn(resetn), .validM(validM), .stallM(stallM), .pcM(pcM),
    .memAddrM(memAddrM), .inDelaySlotM(inDelaySlotM), .isSyscallM(isSyscallM),
    .isBreakM(isBreakM), .isEretM(isEretM), .isLoadAdelM(isLoadAdelM),
    .isStoreAdesM(isStoreAdesM), .isOverflowM(isOverflowM), .isReservedM(isReservedM),
`ifdef EXC_TRAP_EN
    .isTrapM(isTrapM),
`endif
    .intReq(intReq), .statusIE(statusIE), .statusEXL(statusEXL), .statusIM(statusIM),
    .epcIn(epcIn), .redirectReady(redirectReady), .flushReq(flushReq), .cp0We(cp0We),
    .badVAddrWe(badVAddrWe), .excCode(excCode), .epcOut(epcOut), .bdOut(bdOut),
    .badVAddr(badVAddr), .eretTaken(eretTaken), .redirectValid(redirectValid),
    .redirectPc(redirectPc), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          cap, take;
    bit          pres[9];
    logic [4:0]  codes[9];
    int          asel[9];
    int          idx;
    logic [7:0]  clr;
    codes = '{5'h00, 5'h04, 5'h0a, 5'h0c, 5'h0d, 5'h08, 5'h09, 5'h04, 5'h05};
    asel  = '{0, 1, 0, 0, 0, 0, 0, 2, 2};
    if (!resetn) begin
      m_phase = 0; m_pend = '0; m_eret = 0; m_bd = 0; m_badwe = 0;
      m_code = '0; m_epc = '0; m_bad = '0; m_rpc = '0;
      return;
    end
    cap  = validM && !stallM && (m_phase == 0);
    take = statusIE && !statusEXL && ((m_pend & statusIM) != 8'h00);
    pres[0] = take;
    pres[1] = (pcM % 4) != 0;
    pres[2] = isReservedM;
    pres[3] = isOverflowM;
`ifdef EXC_TRAP_EN
    pres[4] = isTrapM;
`else
    pres[4] = 1'b0;
`endif
    pres[5] = isSyscallM;
    pres[6] = isBreakM;
    pres[7] = isLoadAdelM;
    pres[8] = isStoreAdesM;
    idx = -1;
    for (int k = 0; k < 9; k++) if (pres[k] && idx < 0) idx = k;
    clr = (cap && take) ? (m_pend & statusIM) : 8'h00;
    if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (redirectReady) m_phase = 0;
    end else if (cap && (idx >= 0 || isEretM)) begin
      m_phase = 1;
      if (idx >= 0) begin
        m_eret  = 0;
        m_code  = codes[idx];
        m_epc   = inDelaySlotM ? pcM - 32'd4 : pcM;
        m_bd    = inDelaySlotM;
        m_badwe = asel[idx] != 0;
        if (asel[idx] == 1) m_bad = pcM;
        if (asel[idx] == 2) m_bad = memAddrM;
        m_rpc   = 32'hBFC0_0380;
      end else begin
        m_eret = 1;
        m_rpc  = epcIn;
      end
    end
    m_pend = (m_pend | intReq) & ~clr;
  endtask

  task automatic check_all();
    chk("flushReq",      32'(flushReq),      32'(m_phase == 1));
    chk("cp0We",         32'(cp0We),         32'(m_phase == 1 && !m_eret));
    chk("badVAddrWe",    32'(badVAddrWe),    32'(m_phase == 1 && !m_eret && m_badwe));
    chk("eretTaken",     32'(eretTaken),     32'(m_phase == 1 && m_eret));
    chk("redirectValid", 32'(redirectValid), 32'(m_phase == 2));
    chk("busy",          32'(busy),          32'(m_phase != 0));
    chk("excCode",       32'(excCode),       32'(m_code));
    chk("epcOut",        epcOut,             m_epc);
    chk("bdOut",         32'(bdOut),         32'(m_bd));
    chk("badVAddr",      badVAddr,           m_bad);
    chk("redirectPc",    redirectPc,         m_rpc);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    validM = 0; stallM = 0; inDelaySlotM = 0; pcM = '0; memAddrM = '0; epcIn = '0;
    isSyscallM = 0; isBreakM = 0; isEretM = 0; isLoadAdelM = 0; isStoreAdesM = 0;
    isOverflowM = 0; isReservedM = 0; intReq = '0;
`ifdef EXC_TRAP_EN
    isTrapM = 0;
`endif
  endtask

  initial begin
    quiet();
    resetn = 0; statusIE = 0; statusEXL = 0; statusIM = '0; redirectReady = 0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_redirectPc", redirectPc, 32'd0);
    resetn = 1;
    tick();

    // syscall, not in delay slot
    validM = 1; pcM = 32'h0000_1000; isSyscallM = 1;
    tick();
    chk("sys_cp0We", 32'(cp0We), 32'd1);
    chk("sys_code", 32'(excCode), 32'h08);
    chk("sys_epc", epcOut, 32'h1000);
    chk("sys_bd", 32'(bdOut), 32'd0);
    quiet();
    tick();
    chk("sys_rpc", redirectPc, 32'hBFC0_0380);
    redirectReady = 1;
    tick();
    chk("sys_idle", 32'(busy), 32'd0);

    // load AdEL in a delay slot
    validM = 1; pcM = 32'h2004; memAddrM = 32'h1003; inDelaySlotM = 1; isLoadAdelM = 1;
    tick();
    chk("adel_code", 32'(excCode), 32'h04);
    chk("adel_bad", badVAddr, 32'h1003);
    chk("adel_badwe", 32'(badVAddrWe), 32'd1);
    chk("adel_epc", epcOut, 32'h2000);
    chk("adel_bd", 32'(bdOut), 32'd1);
    quiet(); tick(); tick();

    // misaligned fetch beats overflow
    validM = 1; pcM = 32'h3002; isOverflowM = 1;
    tick();
    chk("iadel_code", 32'(excCode), 32'h04);
    chk("iadel_bad", badVAddr, 32'h3002);
    quiet(); tick(); tick();

    // interrupt pulse while busy, taken at next capture
    statusIE = 1; statusEXL = 0; statusIM = 8'h04;
    validM = 1; pcM = 32'h1000; isSyscallM = 1;
    tick();
    quiet(); intReq = 8'h04;
    tick();
    intReq = '0;
    tick();
    validM = 1; pcM = 32'h5000;
    tick();
    chk("int_code", 32'(excCode), 32'h00);
    chk("int_cp0We", 32'(cp0We), 32'd1);
    quiet(); tick(); tick();
    validM = 1; pcM = 32'h5004;
    tick();
    chk("int_cleared", 32'(busy), 32'd0);
    quiet(); statusIE = 0;

    // eret with fetch back-pressure
    validM = 1; pcM = 32'h6000; isEretM = 1; epcIn = 32'h4000; redirectReady = 0;
    tick();
    chk("eret_taken", 32'(eretTaken), 32'd1);
    chk("eret_cp0We", 32'(cp0We), 32'd0);
    quiet();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("eret_hold_valid", 32'(redirectValid), 32'd1);
      chk("eret_hold_pc", redirectPc, 32'h4000);
    end
    redirectReady = 1;
    tick();

    // reset in REDIRECT
    redirectReady = 0; validM = 1; pcM = 32'h7000; isBreakM = 1;
    tick();
    quiet(); tick();
    resetn = 0;
    tick();
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_rv", 32'(redirectValid), 32'd0);
    chk("rstmid_code", 32'(excCode), 32'd0);
    resetn = 1;
    tick();

`ifdef EXC_TRAP_EN
    validM = 1; pcM = 32'h8000; isTrapM = 1; isSyscallM = 1; redirectReady = 1;
    tick();
    chk("trap_code", 32'(excCode), 32'h0d);
    quiet(); tick(); tick();
`endif

    for (int n = 0; n < 4000; n++) begin
      resetn        = ($urandom_range(0, 63) != 0);
      validM        = ($urandom_range(0, 3) != 0);
      stallM        = ($urandom_range(0, 4) == 0);
      pcM           = {$urandom_range(0, 32'hFFFF), 2'b00};
      if ($urandom_range(0, 9) == 0) pcM[1:0] = 2'($urandom_range(1, 3));
      memAddrM      = $urandom;
      inDelaySlotM  = $urandom_range(0, 1);
      isSyscallM    = ($urandom_range(0, 11) == 0);
      isBreakM      = ($urandom_range(0, 11) == 0);
      isEretM       = ($urandom_range(0, 9) == 0);
      isLoadAdelM   = ($urandom_range(0, 11) == 0);
      isStoreAdesM  = ($urandom_range(0, 11) == 0);
      isOverflowM   = ($urandom_range(0, 11) == 0);
      isReservedM   = ($urandom_range(0, 11) == 0);
`ifdef EXC_TRAP_EN
      isTrapM       = ($urandom_range(0, 11) == 0);
`endif
      intReq        = '0;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 29) == 0) intReq[b] = 1'b1;
      statusIE      = ($urandom_range(0, 4) != 0);
      statusEXL     = ($urandom_range(0, 6) == 0);
      statusIM      = 8'($urandom);
      epcIn         = $urandom;
      redirectReady = $urandom_range(0, 1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
